// File: rtl/sumador_pkg.sv
// +----------------------------------------------------------------------+
// | sumador_pkg: shared state encoding and default width for the serial  |
// | adder/subtractor.                                                    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package sumador_pkg;

    localparam int ANCHO_DEF = 8;

    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        SUMANDO  = 2'd1,
        LISTO    = 2'd2
    } estado_t;

endpackage

`default_nettype wire

// File: rtl/sumador_completo.sv
// +----------------------------------------------------------------------+
// | sumador_completo: one-bit full adder used as the serial bit-slice.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module sumador_completo (
    input  logic a,
    input  logic b,
    input  logic acarreo_in,
    output logic suma_bit,
    output logic acarreo_out
);

    assign suma_bit    = a ^ b ^ acarreo_in;
    assign acarreo_out = (a & b) | (acarreo_in & (a ^ b));

endmodule

`default_nettype wire

// File: rtl/sumador_serial.sv
// +----------------------------------------------------------------------+
// | sumador_serial: bit-serial ANCHO-bit adder, LSB first, with valid/   |
// | ready handshakes. SUMADOR_SERIAL_RESTA_EN enables A-B via `resta`.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module sumador_serial
    import sumador_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ANCHO-1:0] op_a,
    input  logic [ANCHO-1:0] op_b,
    input  logic             acarreo_in,
    input  logic             resta,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ANCHO-1:0] resultado,
    output logic             acarreo_out,
    output logic             desbordamiento
);

    localparam int             CW       = (ANCHO > 1) ? $clog2(ANCHO) : 1;
    localparam logic [CW-1:0]  C_ULTIMO = CW'(ANCHO - 1);

    estado_t          estado_q, estado_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [ANCHO-1:0] a_q, a_d;
    logic [ANCHO-1:0] b_q, b_d;
    logic [ANCHO-2:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [ANCHO-1:0] res_q, res_d;
    logic             co_q, co_d;
    logic             ov_q, ov_d;

    logic [ANCHO-1:0] w_b_cap;
    logic             w_ci_cap;
    logic             w_suma;
    logic             w_co;
    logic [ANCHO-1:0] w_acc_sig;

`ifdef SUMADOR_SERIAL_RESTA_EN
    assign w_b_cap  = resta ? ~op_b : op_b;
    assign w_ci_cap = resta ? 1'b1  : acarreo_in;
`else
    logic w_unused;
    assign w_unused = resta;
    assign w_b_cap  = op_b;
    assign w_ci_cap = acarreo_in;
`endif

    sumador_completo u_bit (
        .a           (a_q[0]),
        .b           (b_q[0]),
        .acarreo_in  (carry_q),
        .suma_bit    (w_suma),
        .acarreo_out (w_co)
    );

    // Earlier bits sit in acc_q with bit 0 at the LSB once all but the last are in.
    assign w_acc_sig = {w_suma, acc_q};

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        carry_d  = carry_q;
        res_d    = res_q;
        co_d     = co_q;
        ov_d     = ov_q;
        case (estado_q)
            INACTIVO: begin
                if (in_valid) begin
                    estado_d = SUMANDO;
                    a_d      = op_a;
                    b_d      = w_b_cap;
                    carry_d  = w_ci_cap;
                    cnt_d    = '0;
                end
            end
            SUMANDO: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                acc_d   = w_acc_sig[ANCHO-1:1];
                carry_d = w_co;
                if (cnt_q == C_ULTIMO) begin
                    estado_d = LISTO;
                    res_d    = w_acc_sig;
                    co_d     = w_co;
                    ov_d     = carry_q ^ w_co;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LISTO: begin
                if (out_ready) begin
                    estado_d = INACTIVO;
                end
            end
            default: estado_d = INACTIVO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= INACTIVO;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            carry_q  <= 1'b0;
            res_q    <= '0;
            co_q     <= 1'b0;
            ov_q     <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            carry_q  <= carry_d;
            res_q    <= res_d;
            co_q     <= co_d;
            ov_q     <= ov_d;
        end
    end

    assign in_ready       = (estado_q == INACTIVO);
    assign out_valid      = (estado_q == LISTO);
    assign resultado      = res_q;
    assign acarreo_out    = co_q;
    assign desbordamiento = ov_q;

endmodule

`default_nettype wire

// File: doc/sumador_serial.md
# sumador_serial

Bit-serial N-bit adder/subtractor for the ALU datapath. It is the sequencing stage directly upstream of the one-bit full adder `sumador_completo`. It accepts a pair of operands over a valid/ready handshake and feeds one bit pair per clock, LSB first, into a single `sumador_completo` instance. It registers the carry between bits, assembles the result, and presents it with carry and signed-overflow flags over an output valid/ready handshake.

## Interface
- `ANCHO`, default 8: operand/result width in bits; legal range 2..32.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operands present.
- `in_ready`  out  1: block can accept operands.
- `op_a`  in  ANCHO: operand A.
- `op_b`  in  ANCHO: operand B.
- `acarreo_in`  in  1: carry-in for addition; ignored on subtraction.
- `resta`  in  1: 1 selects A−B. Only honoured with `SUMADOR_SERIAL_RESTA_EN`.
- `out_valid`  out  1: result available.
- `out_ready`  in  1: consumer takes result.
- `resultado`  out  ANCHO: sum/difference.
- `acarreo_out`  out  1: carry out of the MSB. On subtraction, 1 means no borrow (A ≥ B unsigned).
- `desbordamiento`  out  1: two's-complement overflow, computed as the carry into the MSB XOR the carry out of the MSB.

## Operation
- FSM states:
  - INACTIVO: `in_ready`=1.
  - SUMANDO: shifting bits.
  - LISTO: `out_valid`=1.
- INACTIVO→SUMANDO on `in_valid & in_ready`. At that edge:
  - capture `op_a` into shift register A;
  - capture `op_b` into shift register B, or `~op_b` when subtracting;
  - set the carry register to `acarreo_in`, or to 1 when subtracting;
  - clear the bit counter.
- SUMANDO, each cycle:
  - bit A[0], bit B[0] and the carry register drive `sumador_completo`;
  - at the edge, `suma_bit` shifts into the result MSB (result shifts right);
  - A and B shift right, the carry register takes `acarreo_out` of the full adder, and the counter increments.
- On the edge where the counter equals ANCHO−1:
  - register the final carry to `acarreo_out`;
  - register carry-in XOR carry-out of that bit to `desbordamiento`;
  - go to LISTO.
- LISTO→INACTIVO on `out_valid & out_ready`. Outputs hold stable while `out_ready`=0.
- No overlap: `in_ready`=0 in SUMANDO and LISTO. A new operation is accepted only from INACTIVO, i.e. at the earliest one cycle after the output handshake.
- Reset (any state, mid-operation included) aborts the operation and forces the following values:
  - state INACTIVO, counter 0, all shift/carry registers 0;
  - `in_ready`=1, `out_valid`=0, `resultado`=0, `acarreo_out`=0, `desbordamiento`=0.
- Arithmetic is modulo 2^ANCHO. The counter is ⌈log2 ANCHO⌉ bits wide and never wraps past ANCHO−1.

## Timing
- Accept edge E0. Bits are processed on edges E1..E_ANCHO.
- `out_valid` is asserted after edge E_ANCHO, so latency from accept to `out_valid` is ANCHO cycles.
- With `out_ready` held at 1, `in_ready` returns 1 ANCHO+1 cycles after E0. Throughput is one operation per ANCHO+2 cycles.
- Outputs are registered. The only combinational path is none: `in_ready` and `out_valid` are decoded from state registers.
- `resultado` changes only on the edge entering LISTO. It holds its value in INACTIVO until the next completion.

## Configuration
- `SUMADOR_SERIAL_RESTA_EN` defined:
  - `resta`=1 captures `~op_b` and forces initial carry 1;
  - `resta`=0 adds with `acarreo_in`.
- Not defined:
  - the `resta` port is present but ignored, and every operation is A+B+`acarreo_in`;
  - no inverter logic is synthesized.

## Structure
- Package `sumador_pkg`:
  - state enum typedef (INACTIVO, SUMANDO, LISTO);
  - `ANCHO_DEF` = 8.
- One sub-module: `sumador_completo`, instantiated once as the bit-slice. No other hierarchy.

## Test plan
All cases use ANCHO=8.
- 0x0F + 0x01, ci=0 → `resultado`=0x10, `acarreo_out`=0, `desbordamiento`=0; `out_valid` exactly 8 cycles after the accept edge.
- 0xFF + 0x01, ci=0 → 0x00, co=1, ov=0. Then 0x00 + 0x00, ci=1 → 0x01, co=0.
- 0x7F + 0x01 → 0x80, co=0, ov=1. 0x80 + 0x80 → 0x00, co=1, ov=1.
- With RESTA_EN: 0x05 − 0x07 → 0xFE, co=0, ov=0. 0x80 − 0x01 → 0x7F, co=1, ov=1. Without RESTA_EN, the same stimulus with `resta`=1 → 0x0C.
- Backpressure: hold `out_ready`=0 for 3 cycles in LISTO → outputs stable, `in_ready`=0, `in_valid` ignored. Result accepted on the 4th cycle; `in_ready`=1 the next cycle.
- Assert `rst_n`=0 at bit 4 of an operation → all outputs at reset values immediately (asynchronously). After release, a fresh 0x01 + 0x02 → 0x03 with 8-cycle latency.
